// File: rtl/prg_tile_sched.sv
// Frame scheduler for the primary ray generator: walks one frame in tile order and
// issues (x,y) under a valid/stall handshake, throttled by a rays-in-flight credit count.
module prg_tile_sched #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int TILE_W       = 8,
  parameter int TILE_H       = 8,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       v0,
  input  logic       pix_stall,
  input  logic       ray_retire,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] inflight,
  output logic       retire_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [9:0] X_TILE_LAST = 10'(TILE_W - 1);
  localparam logic [8:0] Y_TILE_LAST = 9'(TILE_H - 1);
  localparam logic [9:0] X_BASE_LAST = 10'(SCREEN_W - TILE_W);
  localparam logic [8:0] Y_TOP_FIRST = 9'(SCREEN_H - 1);
  localparam logic [8:0] Y_TOP_LAST  = 9'(TILE_H - 1);
  localparam logic [9:0] X_STEP      = 10'(TILE_W);
  localparam logic [8:0] Y_STEP      = 9'(TILE_H);
  localparam logic [7:0] CREDITS     = 8'(MAX_INFLIGHT);

  state_t     state, state_nxt;
  logic [9:0] base_x, off_x;
  logic [8:0] top_y, off_y;
  logic       accept, last_pix, retire_ok, load_first;
  logic       end_x, end_y, end_row, end_frame;

  assign pix_valid  = (state == S_ISSUE) && v0 && (inflight < CREDITS);
  assign accept     = pix_valid && !pix_stall;
  assign retire_ok  = ray_retire && (inflight != 8'd0);
  assign load_first = (state == S_IDLE) && start;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  assign end_x     = (off_x == X_TILE_LAST);
  assign end_y     = (off_y == Y_TILE_LAST);
  assign end_row   = (base_x == X_BASE_LAST);
  assign end_frame = (top_y == Y_TOP_LAST);
  assign last_pix  = end_x && end_y && end_row && end_frame;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if ((accept && last_pix) || abort) state_nxt = S_DRAIN;
      S_DRAIN: if (inflight == 8'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pixel walker: x within tile, then rows downward, then next tile right, then next tile row down.
  // The last pixel of the frame is held rather than wrapped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_x <= '0;
      top_y  <= Y_TOP_FIRST;
      off_x  <= '0;
      off_y  <= '0;
      pix_x  <= '0;
      pix_y  <= Y_TOP_FIRST;
    end else if (load_first) begin
      base_x <= '0;
      top_y  <= Y_TOP_FIRST;
      off_x  <= '0;
      off_y  <= '0;
      pix_x  <= '0;
      pix_y  <= Y_TOP_FIRST;
    end else if (accept && !last_pix) begin
      if (!end_x) begin
        off_x <= off_x + 10'd1;
        pix_x <= pix_x + 10'd1;
      end else if (!end_y) begin
        off_x <= '0;
        off_y <= off_y + 9'd1;
        pix_x <= base_x;
        pix_y <= pix_y - 9'd1;
      end else if (!end_row) begin
        off_x  <= '0;
        off_y  <= '0;
        base_x <= base_x + X_STEP;
        pix_x  <= base_x + X_STEP;
        pix_y  <= top_y;
      end else begin
        off_x  <= '0;
        off_y  <= '0;
        base_x <= '0;
        top_y  <= top_y - Y_STEP;
        pix_x  <= '0;
        pix_y  <= top_y - Y_STEP;
      end
    end
  end

  // Credit counter: a retire with nothing outstanding is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= '0;
      retire_err <= 1'b0;
    end else begin
      if (accept && !retire_ok)      inflight <= inflight + 8'd1;
      else if (!accept && retire_ok) inflight <= inflight - 8'd1;
      if (ray_retire && (inflight == 8'd0)) retire_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                   aborted <= 1'b0;
    else if (load_first)                                        aborted <= 1'b0;
    else if (abort && (state == S_ISSUE || state == S_DRAIN))   aborted <= 1'b1;
  end

endmodule
